// File: rtl/processor_pkg.sv
// Shared encodings for the RV32I single-cycle core: opcodes, funct fields,
// ALU operation and write-back source enums, and the load extension helper.
package processor_pkg;

  // Major opcodes
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // Integer ALU funct3
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // Branch funct3
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Load / store funct3
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // funct7 selecting SUB / SRA / SRAI
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_LINK = 2'd2
  } wb_sel_e;

  // Sign/zero extend the raw little-endian load word according to funct3
  function automatic logic [31:0] load_extend(input logic [31:0] raw, input logic [2:0] f3);
    logic [31:0] res;
    case (f3)
      F3_LB:   res = {{24{raw[7]}}, raw[7:0]};
      F3_LH:   res = {{16{raw[15]}}, raw[15:0]};
      F3_LW:   res = raw;
      F3_LBU:  res = {24'h000000, raw[7:0]};
      F3_LHU:  res = {16'h0000, raw[15:0]};
      default: res = 32'h0000_0000;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/processor_alu.sv
// Combinational integer ALU. Also produces branch compare results:
// SUB (zero test) for BEQ/BNE, SLT/SLTU (bit 0) for the ordered branches.
module processor_alu
  import processor_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_e          op,
  output logic [WIDTH-1:0] result
);

  localparam int SW = $clog2(WIDTH);

  // Operation select; shift amount is the low bits of b
  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLL:  result = a << b[SW-1:0];
      ALU_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: result = {{(WIDTH-1){1'b0}}, (a < b)};
      ALU_XOR:  result = a ^ b;
      ALU_SRL:  result = a >> b[SW-1:0];
      ALU_SRA:  result = $signed(a) >>> b[SW-1:0];
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/processor.sv
// Single-cycle RV32I core with unified byte-addressed little-endian memory.
// Fetch, decode, execute and load are combinational; PC, rd and store bytes
// update on the rising clock edge. All memory indices wrap modulo MEM_DEPTH.
module processor
  import processor_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int NUM_REGS   = 32,
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 16384
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             memEn,
  input  logic [31:0]      memData,
  input  logic [31:0]      memAddr,
  output logic [WIDTH-1:0] gp,
  output logic [WIDTH-1:0] a7,
  output logic [WIDTH-1:0] a0
);

  localparam int AW = $clog2(MEM_DEPTH);

  logic [WIDTH-1:0]      registers  [NUM_REGS];
  logic [DATA_WIDTH-1:0] mainMemory [MEM_DEPTH];
  logic [WIDTH-1:0]      pc_r;

  logic [AW-1:0]    fetch_idx_s [4];
  logic [AW-1:0]    data_idx_s  [4];
  logic [AW-1:0]    ext_idx_s   [4];
  logic [31:0]      instr_s;
  logic [31:0]      load_raw_s;

  logic [6:0]       opcode_s;
  logic [4:0]       rd_s;
  logic [2:0]       f3_s;
  logic [4:0]       rs1_s;
  logic [4:0]       rs2_s;
  logic [6:0]       f7_s;
  logic [WIDTH-1:0] imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s;
  logic [WIDTH-1:0] rs1_val_s, rs2_val_s;

  alu_op_e          alu_op_s;
  logic [WIDTH-1:0] alu_a_s, alu_b_s, alu_result_s;
  wb_sel_e          wb_sel_s;
  logic             reg_we_s;
  logic [3:0]       store_mask_s;
  logic             is_branch_s, is_jal_s, is_jalr_s;
  logic             branch_taken_s;
  logic [WIDTH-1:0] pc_plus4_s, next_pc_s, rd_data_s;
  logic             unused_s;

  assign unused_s = ^memAddr[31:AW];

  // Byte indices for fetch, data access and external writes, each wrapping
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      fetch_idx_s[k] = pc_r[AW-1:0] + AW'(k);
      data_idx_s[k]  = alu_result_s[AW-1:0] + AW'(k);
      ext_idx_s[k]   = memAddr[AW-1:0] + AW'(k);
    end
  end

  // Instruction fetch, little-endian from the current PC
  always_comb begin
    instr_s = 32'h0000_0000;
    for (int k = 0; k < 4; k++) begin
      instr_s[8*k +: 8] = mainMemory[fetch_idx_s[k]];
    end
  end

  // Field extraction, immediates and x0-aware register reads
  always_comb begin
    opcode_s  = instr_s[6:0];
    rd_s      = instr_s[11:7];
    f3_s      = instr_s[14:12];
    rs1_s     = instr_s[19:15];
    rs2_s     = instr_s[24:20];
    f7_s      = instr_s[31:25];
    imm_i_s   = {{20{instr_s[31]}}, instr_s[31:20]};
    imm_s_s   = {{20{instr_s[31]}}, instr_s[31:25], instr_s[11:7]};
    imm_b_s   = {{19{instr_s[31]}}, instr_s[31], instr_s[7], instr_s[30:25], instr_s[11:8], 1'b0};
    imm_u_s   = {instr_s[31:12], 12'h000};
    imm_j_s   = {{11{instr_s[31]}}, instr_s[31], instr_s[19:12], instr_s[20], instr_s[30:21], 1'b0};
    rs1_val_s = (rs1_s == 5'd0) ? '0 : registers[rs1_s];
    rs2_val_s = (rs2_s == 5'd0) ? '0 : registers[rs2_s];
  end

  // Decode: ALU operands/op, write-back source, store mask, control-flow kind
  always_comb begin
    alu_op_s     = ALU_ADD;
    alu_a_s      = rs1_val_s;
    alu_b_s      = imm_i_s;
    wb_sel_s     = WB_ALU;
    reg_we_s     = 1'b0;
    store_mask_s = 4'b0000;
    is_branch_s  = 1'b0;
    is_jal_s     = 1'b0;
    is_jalr_s    = 1'b0;
    case (opcode_s)
      OPC_LUI: begin
        alu_a_s  = '0;
        alu_b_s  = imm_u_s;
        reg_we_s = 1'b1;
      end
      OPC_AUIPC: begin
        alu_a_s  = pc_r;
        alu_b_s  = imm_u_s;
        reg_we_s = 1'b1;
      end
      OPC_JAL: begin
        wb_sel_s = WB_LINK;
        reg_we_s = 1'b1;
        is_jal_s = 1'b1;
      end
      OPC_JALR: begin
        wb_sel_s  = WB_LINK;
        reg_we_s  = 1'b1;
        is_jalr_s = 1'b1;
      end
      OPC_BRANCH: begin
        alu_b_s     = rs2_val_s;
        is_branch_s = 1'b1;
        case (f3_s)
          F3_BLT, F3_BGE:   alu_op_s = ALU_SLT;
          F3_BLTU, F3_BGEU: alu_op_s = ALU_SLTU;
          default:          alu_op_s = ALU_SUB;
        endcase
      end
      OPC_LOAD: begin
        wb_sel_s = WB_LOAD;
        case (f3_s)
          F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: reg_we_s = 1'b1;
          default:                             reg_we_s = 1'b0;
        endcase
      end
      OPC_STORE: begin
        alu_b_s = imm_s_s;
        case (f3_s)
          F3_SB:   store_mask_s = 4'b0001;
          F3_SH:   store_mask_s = 4'b0011;
          F3_SW:   store_mask_s = 4'b1111;
          default: store_mask_s = 4'b0000;
        endcase
      end
      OPC_OP_IMM, OPC_OP: begin
        reg_we_s = 1'b1;
        alu_b_s  = (opcode_s == OPC_OP) ? rs2_val_s : imm_i_s;
        case (f3_s)
          F3_ADD:  alu_op_s = ((opcode_s == OPC_OP) && (f7_s == F7_ALT)) ? ALU_SUB : ALU_ADD;
          F3_SLL:  alu_op_s = ALU_SLL;
          F3_SLT:  alu_op_s = ALU_SLT;
          F3_SLTU: alu_op_s = ALU_SLTU;
          F3_XOR:  alu_op_s = ALU_XOR;
          F3_SR:   alu_op_s = (f7_s == F7_ALT) ? ALU_SRA : ALU_SRL;
          F3_OR:   alu_op_s = ALU_OR;
          F3_AND:  alu_op_s = ALU_AND;
          default: alu_op_s = ALU_ADD;
        endcase
      end
      OPC_MISC_MEM, OPC_SYSTEM: begin
        reg_we_s = 1'b0;
      end
      default: begin
        reg_we_s = 1'b0;
      end
    endcase
  end

  processor_alu #(.WIDTH(WIDTH)) u_alu (
    .a      (alu_a_s),
    .b      (alu_b_s),
    .op     (alu_op_s),
    .result (alu_result_s)
  );

  // Data read, little-endian from the effective address
  always_comb begin
    load_raw_s = 32'h0000_0000;
    for (int k = 0; k < 4; k++) begin
      load_raw_s[8*k +: 8] = mainMemory[data_idx_s[k]];
    end
  end

  // Branch resolution, next PC and rd write-back value
  always_comb begin
    pc_plus4_s = pc_r + 32'd4;
    case (f3_s)
      F3_BEQ:           branch_taken_s = (alu_result_s == '0);
      F3_BNE:           branch_taken_s = (alu_result_s != '0);
      F3_BLT, F3_BLTU:  branch_taken_s = alu_result_s[0];
      F3_BGE, F3_BGEU:  branch_taken_s = ~alu_result_s[0];
      default:          branch_taken_s = 1'b0;
    endcase
    if (is_jal_s) begin
      next_pc_s = pc_r + imm_j_s;
    end else if (is_jalr_s) begin
      next_pc_s = {alu_result_s[WIDTH-1:1], 1'b0};
    end else if (is_branch_s && branch_taken_s) begin
      next_pc_s = pc_r + imm_b_s;
    end else begin
      next_pc_s = pc_plus4_s;
    end
    case (wb_sel_s)
      WB_LOAD: rd_data_s = load_extend(load_raw_s, f3_s);
      WB_LINK: rd_data_s = pc_plus4_s;
      default: rd_data_s = alu_result_s;
    endcase
  end

  // Program counter; reset returns execution to address 0
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_r <= '0;
    end else begin
      pc_r <= next_pc_s;
    end
  end

  // Register file write; x0 is never written and nothing is written in reset
  always_ff @(posedge clock) begin
    if (!reset && reg_we_s && (rd_s != 5'd0)) begin
      registers[rd_s] <= rd_data_s;
    end
  end

  // Memory writes: core store first, external port last so it wins on overlap
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int k = 0; k < 4; k++) begin
        if (store_mask_s[k]) begin
          mainMemory[data_idx_s[k]] <= rs2_val_s[8*k +: 8];
        end
      end
    end
    if (memEn) begin
      for (int k = 0; k < 4; k++) begin
        mainMemory[ext_idx_s[k]] <= memData[8*k +: 8];
      end
    end
  end

  assign gp = registers[3];
  assign a7 = registers[17];
  assign a0 = registers[10];

endmodule

// File: tb/tb_processor.sv
// Self-checking bench for the RV32I core: programs are loaded through the
// external write port during reset, expected values are queued as each
// program is set up and popped once the program has run.
module tb_processor;

  logic        clock;
  logic        reset;
  logic        memEn;
  logic [31:0] memData;
  logic [31:0] memAddr;
  logic [31:0] gp, a7, a0;

  int tests_run = 0;
  int tests_failed = 0;

  localparam int SEL_GP  = 0;
  localparam int SEL_A0  = 1;
  localparam int SEL_A7  = 2;
  localparam int SEL_MEM = 3;
  localparam int SEL_PC  = 4;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] addr;
    logic [31:0] exp;
  } sb_entry_t;

  sb_entry_t   sb_q[$];
  logic [31:0] prog[$];

  processor dut (
    .clock   (clock),
    .reset   (reset),
    .memEn   (memEn),
    .memData (memData),
    .memAddr (memAddr),
    .gp      (gp),
    .a7      (a7),
    .a0      (a0)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Instruction encoders
  function automatic logic [31:0] f_itype(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] f_rtype(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] f_stype(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] f_btype(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] f_utype(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rd, op};
  endfunction
  function automatic logic [31:0] f_jtype(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
  endfunction
  function automatic logic [31:0] f_addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return f_itype(imm, rs1, 3'b000, rd, 7'h13);
  endfunction

  task automatic check_result(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic expect_val(input string tag, input int sel, input logic [31:0] addr, input logic [31:0] exp);
    sb_entry_t e;
    e.tag = tag; e.sel = sel; e.addr = addr; e.exp = exp;
    sb_q.push_back(e);
  endtask

  // Pop every queued expectation and compare with the DUT state now
  task automatic drain();
    sb_entry_t   e;
    logic [31:0] obs;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.sel)
        SEL_GP:  obs = gp;
        SEL_A0:  obs = a0;
        SEL_A7:  obs = a7;
        SEL_MEM: obs = {24'h000000, dut.mainMemory[e.addr[13:0]]};
        SEL_PC:  obs = dut.pc_r;
        default: obs = 32'hXXXX_XXXX;
      endcase
      check_result(e.tag, obs, e.exp);
    end
  endtask

  task automatic load_word(input logic [31:0] addr, input logic [31:0] data);
    memEn   = 1'b1;
    memAddr = addr;
    memData = data;
    @(negedge clock);
    memEn   = 1'b0;
  endtask

  // Hold reset, write the program from address 0, then release reset
  task automatic boot_prog();
    reset = 1'b1;
    for (int i = 0; i < prog.size(); i++) begin
      load_word(32'(i * 4), prog[i]);
    end
    reset = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    reset   = 1'b1;
    memEn   = 1'b0;
    memData = 32'h0;
    memAddr = 32'h0;
    run(2);

    // Reset behaviour
    load_word(32'h0, 32'h0050_0193);
    expect_val("reset_pc", SEL_PC, 32'h0, 32'h0);
    drain();
    reset = 1'b0;
    run(1);
    expect_val("addi_gp5", SEL_GP, 32'h0, 32'd5);
    drain();
    reset = 1'b1;
    load_word(32'h0, f_addi(5'd3, 5'd0, 12'd9));
    run(1);
    expect_val("reset_hold_gp", SEL_GP, 32'h0, 32'd5);
    expect_val("reset_hold_pc", SEL_PC, 32'h0, 32'h0);
    drain();
    reset = 1'b0;
    run(1);
    expect_val("after_reset_gp9", SEL_GP, 32'h0, 32'd9);
    drain();

    // Completion signature
    prog = '{f_addi(5'd17, 5'd0, 12'd93), f_addi(5'd3, 5'd0, 12'd1)};
    boot_prog();
    run(2);
    expect_val("done_a7", SEL_A7, 32'h0, 32'd93);
    expect_val("done_gp", SEL_GP, 32'h0, 32'd1);
    drain();

    // Stores and loads with wrapped addresses
    prog = '{f_utype(20'h80000, 5'd5, 7'h37),
             f_utype(20'h12345, 5'd6, 7'h37),
             f_addi(5'd6, 5'd6, 12'h678),
             f_stype(12'h000, 5'd6, 5'd5, 3'b010),
             f_itype(12'h000, 5'd5, 3'b000, 5'd10, 7'h03),
             f_itype(12'h002, 5'd5, 3'b001, 5'd10, 7'h03),
             f_addi(5'd7, 5'd0, 12'hFFF),
             f_stype(12'h100, 5'd7, 5'd5, 3'b000),
             f_itype(12'h100, 5'd5, 3'b000, 5'd10, 7'h03),
             f_itype(12'h100, 5'd5, 3'b100, 5'd10, 7'h03)};
    boot_prog();
    run(5);
    expect_val("lb_wrap", SEL_A0, 32'h0, 32'h0000_0078);
    expect_val("sw_byte0", SEL_MEM, 32'h0, 32'h78);
    expect_val("sw_byte3", SEL_MEM, 32'h3, 32'h12);
    drain();
    run(1);
    expect_val("lh_hi", SEL_A0, 32'h0, 32'h0000_1234);
    drain();
    run(3);
    expect_val("lb_neg", SEL_A0, 32'h0, 32'hFFFF_FFFF);
    drain();
    run(1);
    expect_val("lbu", SEL_A0, 32'h0, 32'h0000_00FF);
    drain();

    // Control flow
    prog = '{f_addi(5'd3, 5'd0, 12'd7),
             f_btype(13'd8, 5'd0, 5'd0, 3'b000),
             f_addi(5'd3, 5'd0, 12'd99),
             f_jtype(21'd8, 5'd10),
             f_addi(5'd3, 5'd0, 12'd55),
             f_addi(5'd11, 5'd0, 12'd33),
             f_itype(12'd0, 5'd11, 3'b000, 5'd0, 7'h67),
             f_addi(5'd3, 5'd0, 12'd77),
             f_utype(20'hABCDE, 5'd3, 7'h37)};
    boot_prog();
    run(4);
    expect_val("beq_skip_gp", SEL_GP, 32'h0, 32'd7);
    expect_val("jal_link", SEL_A0, 32'h0, 32'd16);
    drain();
    run(2);
    expect_val("jalr_odd_lui", SEL_GP, 32'h0, 32'hABCD_E000);
    drain();

    prog = '{f_utype(20'hABCDE, 5'd3, 7'h37),
             f_addi(5'd0, 5'd0, 12'd0),
             f_utype(20'h00001, 5'd10, 7'h17)};
    boot_prog();
    run(3);
    expect_val("lui_gp", SEL_GP, 32'h0, 32'hABCD_E000);
    expect_val("auipc_a0", SEL_A0, 32'h0, 32'h0000_1008);
    drain();

    // Arithmetic edge cases and ordered branches
    prog = '{f_addi(5'd3, 5'd0, 12'd5),
             f_addi(5'd0, 5'd0, 12'd7),
             f_rtype(7'h00, 5'd0, 5'd0, 3'b000, 5'd3),
             f_utype(20'h80000, 5'd13, 7'h37),
             f_addi(5'd14, 5'd0, 12'd31),
             f_rtype(7'h20, 5'd14, 5'd13, 3'b101, 5'd10),
             f_addi(5'd12, 5'd0, 12'd1),
             f_addi(5'd15, 5'd0, 12'hFFF),
             f_rtype(7'h00, 5'd12, 5'd15, 3'b010, 5'd10),
             f_rtype(7'h00, 5'd12, 5'd15, 3'b011, 5'd10),
             f_rtype(7'h20, 5'd12, 5'd0, 3'b000, 5'd10),
             f_btype(13'd8, 5'd12, 5'd15, 3'b100),
             f_addi(5'd3, 5'd0, 12'd1),
             f_btype(13'd8, 5'd12, 5'd15, 3'b110),
             f_addi(5'd10, 5'd0, 12'd2),
             f_rtype(7'h00, 5'd14, 5'd13, 3'b101, 5'd10),
             f_itype(12'h404, 5'd13, 3'b101, 5'd10, 7'h13)};
    boot_prog();
    run(3);
    expect_val("x0_discard", SEL_GP, 32'h0, 32'h0);
    drain();
    run(3);
    expect_val("sra31", SEL_A0, 32'h0, 32'hFFFF_FFFF);
    drain();
    run(3);
    expect_val("slt_signed", SEL_A0, 32'h0, 32'd1);
    drain();
    run(1);
    expect_val("sltu_unsigned", SEL_A0, 32'h0, 32'd0);
    drain();
    run(1);
    expect_val("sub_wrap", SEL_A0, 32'h0, 32'hFFFF_FFFF);
    drain();
    run(3);
    expect_val("blt_taken", SEL_GP, 32'h0, 32'h0);
    expect_val("bltu_not_taken", SEL_A0, 32'h0, 32'd2);
    drain();
    run(1);
    expect_val("srl31", SEL_A0, 32'h0, 32'd1);
    drain();
    run(1);
    expect_val("srai4", SEL_A0, 32'h0, 32'hF800_0000);
    drain();

    // External write port
    reset = 1'b1;
    load_word(32'h10, 32'hDEAD_BEEF);
    expect_val("ext_b0", SEL_MEM, 32'h10, 32'hEF);
    expect_val("ext_b1", SEL_MEM, 32'h11, 32'hBE);
    expect_val("ext_b2", SEL_MEM, 32'h12, 32'hAD);
    expect_val("ext_b3", SEL_MEM, 32'h13, 32'hDE);
    drain();
    prog = '{f_itype(12'h010, 5'd0, 3'b010, 5'd10, 7'h03),
             f_stype(12'h200, 5'd0, 5'd0, 3'b000)};
    boot_prog();
    run(1);
    expect_val("lw_ext", SEL_A0, 32'h0, 32'hDEAD_BEEF);
    drain();
    load_word(32'h200, 32'hCAFE_F00D);
    expect_val("ext_wins_b0", SEL_MEM, 32'h200, 32'h0D);
    expect_val("ext_wins_b1", SEL_MEM, 32'h201, 32'hF0);
    drain();
    reset = 1'b1;
    load_word(32'h3FFE, 32'h1122_3344);
    expect_val("ext_wrap_3ffe", SEL_MEM, 32'h3FFE, 32'h44);
    expect_val("ext_wrap_3fff", SEL_MEM, 32'h3FFF, 32'h33);
    expect_val("ext_wrap_0", SEL_MEM, 32'h0, 32'h22);
    expect_val("ext_wrap_1", SEL_MEM, 32'h1, 32'h11);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
